rsa_operand_loader: RTL and testbench

- Upstream input stage of the RSA-256 core.
- Deserialises the 32-bit host word stream into three 256-bit operands, in this order:
  - message M: 8 words
  - exponent E: 8 words
  - modulus N: 8 words
- Hands the complete operand set to the core over a valid/ready handshake.
- Also provides the exponent's leading-one index, so the core can skip leading zero bits, and rejects even moduli.

---
 rtl/rsa_operand_loader.sv | 193 +++++++++++++++++++
 tb/tb_rsa_operand_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : rsa_operand_loader
// Purpose  : Deserialises the host word stream into the RSA operands M, E, N
//            (MSW first), tracks the exponent's leading-one index, rejects
//            even moduli and hands the operand set to the core via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_operand_loader #(
    parameter int WORD_W = 32,
    parameter int KEY_W  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WORD_W-1:0] data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [KEY_W-1:0]  msg,
    output logic [KEY_W-1:0]  exp,
    output logic [KEY_W-1:0]  mod,
    output logic [IDX_W-1:0]  exp_msb_idx,
    output logic              exp_zero,
    output logic              err_mod_even,
    output logic              abort
);

    localparam int WORDS = KEY_W / WORD_W;
    localparam int SLOTS = 3 * WORDS;
    localparam int CNT_W = $clog2(SLOTS);
    localparam int P_W   = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] c_exp_lo    = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] c_exp_hi    = CNT_W'(2 * WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        LOAD      = 3'd2,
        VALID     = 3'd3,
        WAIT_DROP = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_msg;
    logic [KEY_W-1:0]   r_exp;
    logic [KEY_W-1:0]   r_mod;
    logic [IDX_W-1:0]   r_idx;
    logic               r_exp_zero;
    logic               r_err;
    logic               r_abort;

    logic               w_capture;
    logic               w_last;
    logic               w_abort;
    logic               w_err;
    logic [CNT_W-1:0]   w_slot;
    logic               w_exp_word;
    logic [P_W-1:0]     w_p;
    logic [IDX_W-1:0]   w_word_num;
    logic [IDX_W-1:0]   w_idx;

    // The arm-to-load edge always carries word 0; afterwards the counter names the slot.
    assign w_slot     = (r_state == ARM) ? '0 : r_cnt;
    assign w_exp_word = (w_slot >= c_exp_lo) && (w_slot < c_exp_hi);

    // Leading-one position within the current host word.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (data[i]) begin
                w_p = P_W'(i);
            end
        end
    end

    // Exponent word k sits at slot WORDS+k; its bit offset is (WORDS-1-k)*WORD_W.
    assign w_word_num = IDX_W'(2 * WORDS - 1) - IDX_W'(w_slot);
    assign w_idx      = w_word_num * IDX_W'(WORD_W) + IDX_W'(w_p);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus capture/pulse strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        w_abort     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (enable) begin
                    w_capture   = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (!enable) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_capture = 1'b1;
                    if (r_cnt == c_last_slot) begin
                        w_last = 1'b1;
                        if (data[0]) begin
                            w_state_nxt = VALID;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = WAIT_DROP;
                        end
                    end
                end
            end
            VALID: begin
                if (op_ready) begin
                    w_state_nxt = enable ? WAIT_DROP : IDLE;
                end
            end
            WAIT_DROP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift-in, slot counter, exponent index tracking and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_msg      <= '0;
            r_exp      <= '0;
            r_mod      <= '0;
            r_idx      <= '0;
            r_exp_zero <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_err   <= w_err;
            r_abort <= w_abort;
            r_cnt   <= (w_capture && !w_last) ? w_slot + CNT_W'(1) : '0;
            if (w_capture) begin
                if (w_slot < c_exp_lo) begin
                    r_msg <= {r_msg[KEY_W-WORD_W-1:0], data};
                end else if (w_slot < c_exp_hi) begin
                    r_exp <= {r_exp[KEY_W-WORD_W-1:0], data};
                end else begin
                    r_mod <= {r_mod[KEY_W-WORD_W-1:0], data};
                end
            end
            if (w_capture && (r_state == ARM)) begin
                r_exp_zero <= 1'b1;
                r_idx      <= '0;
            end else if (w_capture && w_exp_word && r_exp_zero && (|data)) begin
                r_exp_zero <= 1'b0;
                r_idx      <= w_idx;
            end
        end
    end

    assign op_valid     = (r_state == VALID);
    assign msg          = r_msg;
    assign exp          = r_exp;
    assign mod          = r_mod;
    assign exp_msb_idx  = r_idx;
    assign exp_zero     = r_exp_zero;
    assign err_mod_even = r_err;
    assign abort        = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_operand_loader
// Purpose  : Directed self-checking bench for rsa_operand_loader with an
//            expected-operand scoreboard popped at each core transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_operand_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [31:0]  data;
    logic         op_valid;
    logic         op_ready;
    logic [255:0] msg;
    logic [255:0] expo;
    logic [255:0] modo;
    logic [7:0]   exp_msb_idx;
    logic         exp_zero;
    logic         err_mod_even;
    logic         abort;

    typedef struct {
        logic [255:0] m;
        logic [255:0] e;
        logic [255:0] n;
        logic [7:0]   idx;
        logic         z;
    } frame_t;

    frame_t sb[$];
    int     n_pass  = 0;
    int     n_total = 0;

    rsa_operand_loader #(.WORD_W(32), .KEY_W(256), .IDX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .data         (data),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .msg          (msg),
        .exp          (expo),
        .mod          (modo),
        .exp_msb_idx  (exp_msb_idx),
        .exp_zero     (exp_zero),
        .err_mod_even (err_mod_even),
        .abort        (abort)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    endtask

    // Reference: highest set bit of the full exponent vector.
    function automatic logic [7:0] msb_idx(input logic [255:0] e);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = i[7:0];
        end
        return r;
    endfunction

    // Arm edge (with a junk word that must be ignored) then nwords captures.
    task automatic arm_and_send(input logic [255:0] m, input logic [255:0] e,
                                input logic [255:0] n, input int nwords);
        logic [767:0] all;
        all = {m, e, n};
        @(negedge clk);
        enable = 1'b1;
        data   = 32'hDEAD_BEEE;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            data = all[(23 - i) * 32 +: 32];
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [255:0] m, input logic [255:0] e,
                              input logic [255:0] n);
        frame_t f;
        f.m   = m;
        f.e   = e;
        f.n   = n;
        f.idx = msb_idx(e);
        f.z   = (e == 256'd0);
        sb.push_back(f);
        arm_and_send(m, e, n, 24);
    endtask

    // Compare the operand set about to be transferred on the next edge.
    task automatic check_transfer(input string tag);
        frame_t f;
        chk({tag, ".valid"}, op_valid, 1'b1);
        chk({tag, ".sb"}, (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            f = sb.pop_front();
            chk({tag, ".msg"}, msg, f.m);
            chk({tag, ".exp"}, expo, f.e);
            chk({tag, ".mod"}, modo, f.n);
            chk({tag, ".idx"}, exp_msb_idx, f.idx);
            chk({tag, ".zero"}, exp_zero, f.z);
        end
    endtask

    task automatic run_ready_high(input string tag, input logic [255:0] m,
                                  input logic [255:0] e, input logic [255:0] n);
        op_ready = 1'b1;
        send_frame(m, e, n);
        check_transfer(tag);
        @(negedge clk);
        chk({tag, ".done"}, op_valid, 1'b0);
        op_ready = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
    endtask

    logic [255:0] c_m;
    logic [255:0] c_n;
    logic [255:0] c_n_even;
    int           quiet_cnt;

    initial begin
        c_m      = "RSA-256 passed congragulations:)";
        c_n      = 256'hF123456789ABCDEF_0FEDCBA987654321_1122334455667788_99AABBCCDDEEFF01;
        c_n_even = c_n ^ 256'd1;

        rst      = 1'b1;
        enable   = 1'b0;
        data     = 32'd0;
        op_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.valid", op_valid, 1'b0);
        chk("rst.msg", msg, 256'd0);
        chk("rst.exp", expo, 256'd0);
        chk("rst.mod", modo, 256'd0);
        chk("rst.idx", exp_msb_idx, 8'd0);
        chk("rst.zero", exp_zero, 1'b0);
        chk("rst.err", err_mod_even, 1'b0);
        chk("rst.abort", abort, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Normal frame with a held-off core.
        send_frame(c_m, 256'h10001, c_n);
        chk("lat.valid", op_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold.valid", op_valid, 1'b1);
            chk("hold.msg", msg, c_m);
            chk("hold.idx", exp_msb_idx, 8'd16);
        end
        op_ready = 1'b1;
        check_transfer("hs");
        @(negedge clk);
        chk("hs.done", op_valid, 1'b0);
        chk("hs.keep_msg", msg, c_m);
        op_ready = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
        chk("hs.single", op_valid, 1'b0);

        // Ready tied high and exponent index corners.
        run_ready_high("rdy", ~c_m, 256'd1, c_n);
        run_ready_high("e255", c_m, 256'd1 << 255, c_n);
        run_ready_high("e223", c_m, 256'h8000_0000 << 192, c_n);
        run_ready_high("ezero", c_m, 256'd0, c_n);

        // Even modulus: reject, then a held enable must not re-arm.
        arm_and_send(c_m, 256'h10001, c_n_even, 24);
        chk("even.err", err_mod_even, 1'b1);
        chk("even.valid", op_valid, 1'b0);
        @(negedge clk);
        chk("even.err_pulse", err_mod_even, 1'b0);
        quiet_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (op_valid || err_mod_even) quiet_cnt++;
        end
        chk("even.wait_drop", quiet_cnt, 0);
        enable = 1'b0;
        @(negedge clk);
        run_ready_high("post_even", c_m ^ c_n, 256'h7, c_n);

        // Abort after 12 captured words.
        arm_and_send(c_m, 256'h10001, c_n, 12);
        enable = 1'b0;
        @(negedge clk);
        chk("abort.pulse", abort, 1'b1);
        chk("abort.valid", op_valid, 1'b0);
        @(negedge clk);
        chk("abort.end", abort, 1'b0);
        chk("abort.novalid", op_valid, 1'b0);
        run_ready_high("post_abort", c_m, 256'h1234_5678 << 64, c_n);

        // Reset during slot 17.
        arm_and_send(~c_m, 256'd0, c_n, 17);
        rst = 1'b1;
        #1;
        chk("mrst.msg", msg, 256'd0);
        chk("mrst.exp", expo, 256'd0);
        chk("mrst.mod", modo, 256'd0);
        chk("mrst.idx", exp_msb_idx, 8'd0);
        chk("mrst.zero", exp_zero, 1'b0);
        chk("mrst.valid", op_valid, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("mrst.abort", abort, 1'b0);
        chk("mrst.err", err_mod_even, 1'b0);
        run_ready_high("post_rst", c_m, 256'h10001, c_n);

        chk("sb.empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
